// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit registered ALU: data width and opcode enum.
// Optional feature macro used by this slice: ALU8_MUL_EN (enables OP_MUL).
package alu8_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_INC    = 4'd2,
        OP_DEC    = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_XOR    = 4'd6,
        OP_NOT    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_ROL    = 4'd10,
        OP_ROR    = 4'd11,
        OP_MUL    = 4'd12,
        OP_CMP    = 4'd13,
        OP_MAXMIN = 4'd14,
        OP_PASS   = 4'd15
    } alu8_op_e;

endpackage : alu8_pkg

// File: rtl/alu8_comb.sv
// Combinational core of the 8-bit ALU: computes the next values of out1,
// out2 and cout from the current operands and opcode.
// Feature macro: ALU8_MUL_EN -- when defined, OP_MUL is an 8x8 unsigned
// multiply; when undefined no multiplier exists and OP_MUL returns zeros.
module alu8_comb
    import alu8_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    input  logic              i_bin,
    input  logic [3:0]        i_sel,
    output logic [DATA_W-1:0] o_next_out1,
    output logic [DATA_W-1:0] o_next_out2,
    output logic              o_next_cout
);

    alu8_op_e          w_op;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_cmp_diff;

    assign w_op = alu8_op_e'(i_sel);

    // The 9-bit sum/difference carry the carry-out and borrow-out in bit 8;
    // a negative a-b-bin wraps to 256..511, so bit 8 is exactly the borrow.
    assign w_sum      = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};
    assign w_diff     = {1'b0, i_a} - {1'b0, i_b} - {{DATA_W{1'b0}}, i_bin};
    assign w_cmp_diff = i_a - i_b;

`ifdef ALU8_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
`endif

    // Opcode decode: select the result for the current operation.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        o_next_out1 = '0;
        o_next_out2 = '0;
        o_next_cout = 1'b0;
        case (w_op)
            OP_ADD: begin
                o_next_out1 = w_sum[DATA_W-1:0];
                o_next_cout = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_next_out1 = w_diff[DATA_W-1:0];
                o_next_cout = w_diff[DATA_W];
            end
            OP_INC: begin
                o_next_out1 = i_a + 8'd1;
                o_next_cout = (i_a == 8'hFF);
            end
            OP_DEC: begin
                o_next_out1 = i_a - 8'd1;
                o_next_cout = (i_a == 8'h00);
            end
            OP_AND: o_next_out1 = i_a & i_b;
            OP_OR:  o_next_out1 = i_a | i_b;
            OP_XOR: o_next_out1 = i_a ^ i_b;
            OP_NOT: begin
                o_next_out1 = ~i_a;
                o_next_out2 = ~i_b;
            end
            OP_SHL: begin
                o_next_out1 = {i_a[6:0], 1'b0};
                o_next_cout = i_a[7];
            end
            OP_SHR: begin
                o_next_out1 = {1'b0, i_a[7:1]};
                o_next_cout = i_a[0];
            end
            OP_ROL: begin
                o_next_out1 = {i_a[6:0], i_a[7]};
                o_next_cout = i_a[7];
            end
            OP_ROR: begin
                o_next_out1 = {i_a[0], i_a[7:1]};
                o_next_cout = i_a[0];
            end
            OP_MUL: begin
`ifdef ALU8_MUL_EN
                o_next_out1 = w_prod[DATA_W-1:0];
                o_next_out2 = w_prod[2*DATA_W-1:DATA_W];
                o_next_cout = |w_prod[2*DATA_W-1:DATA_W];
`else
                // Multiplier not built: result stays at the all-zero default.
                o_next_out1 = '0;
`endif
            end
            OP_CMP: begin
                o_next_out1 = {5'b0, (i_a > i_b), (i_a == i_b), (i_a < i_b)};
                o_next_out2 = w_cmp_diff;
                o_next_cout = (i_a < i_b);
            end
            OP_MAXMIN: begin
                o_next_out1 = (i_a > i_b) ? i_a : i_b;
                o_next_out2 = (i_a > i_b) ? i_b : i_a;
                o_next_cout = (i_a != i_b);
            end
            OP_PASS: begin
                o_next_out1 = i_a;
                o_next_out2 = i_b;
            end
            default: ;
        endcase
    end

endmodule : alu8_comb

// File: rtl/alu8_unit.sv
// Registered 8-bit ALU execute stage: alu8_comb followed by output registers
// with asynchronous active-low reset. Latency is one cycle, no enable.
// Feature macro: ALU8_MUL_EN (passed through to alu8_comb for OP_MUL).
module alu8_unit
    import alu8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              bin,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              cout
);

    logic [DATA_W-1:0] w_next_out1;
    logic [DATA_W-1:0] w_next_out2;
    logic              w_next_cout;

    logic [DATA_W-1:0] r_out1;
    logic [DATA_W-1:0] r_out2;
    logic              r_cout;

    alu8_comb u_comb (
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .i_bin       (bin),
        .i_sel       (sel),
        .o_next_out1 (w_next_out1),
        .o_next_out2 (w_next_out2),
        .o_next_cout (w_next_cout)
    );

    // Output registers: load a fresh result every cycle, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_out1 <= '0;
            r_out2 <= '0;
            r_cout <= 1'b0;
        end else begin
            r_out1 <= w_next_out1;
            r_out2 <= w_next_out2;
            r_cout <= w_next_cout;
        end
    end

    assign out1 = r_out1;
    assign out2 = r_out2;
    assign cout = r_cout;

endmodule : alu8_unit

// File: tb/tb_alu8_unit.sv
// Self-checking testbench for alu8_unit. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge and compared with a
// behavioural model written from the arithmetic rules of each opcode.
// Honours ALU8_MUL_EN the same way the design does.
module tb_alu8_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       bin;
    logic [3:0] sel;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       cout;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       bin;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ec;
    } vec_t;

    alu8_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .bin   (bin),
        .sel   (sel),
        .out1  (out1),
        .out2  (out2),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: returns {cout, out2, out1} from plain integer arithmetic.
    function automatic logic [16:0] model(input int s, input int x, input int y,
                                          input int ci, input int bi);
        int o1, o2, c, t;
        o1 = 0; o2 = 0; c = 0;
        case (s)
            0: begin t = x + y + ci; o1 = t % 256; c = (t >= 256) ? 1 : 0; end
            1: begin t = x - y - bi; o1 = (t + 512) % 256; c = (t < 0) ? 1 : 0; end
            2: begin o1 = (x + 1) % 256; c = (x == 255) ? 1 : 0; end
            3: begin o1 = (x + 255) % 256; c = (x == 0) ? 1 : 0; end
            4: o1 = x & y;
            5: o1 = x | y;
            6: o1 = x ^ y;
            7: begin o1 = 255 - x; o2 = 255 - y; end
            8: begin o1 = (x * 2) % 256; c = x / 128; end
            9: begin o1 = x / 2; c = x % 2; end
            10: begin o1 = (x * 2) % 256 + x / 128; c = x / 128; end
            11: begin o1 = x / 2 + (x % 2) * 128; c = x % 2; end
            12: begin
`ifdef ALU8_MUL_EN
                t = x * y; o1 = t % 256; o2 = t / 256; c = (t >= 256) ? 1 : 0;
`endif
            end
            13: begin
                o1 = (x > y) ? 4 : ((x == y) ? 2 : 1);
                o2 = (x - y + 256) % 256;
                c  = (x < y) ? 1 : 0;
            end
            14: begin
                o1 = (x > y) ? x : y;
                o2 = (x > y) ? y : x;
                c  = (x != y) ? 1 : 0;
            end
            default: begin o1 = x; o2 = y; end
        endcase
        return {c[0], o2[7:0], o1[7:0]};
    endfunction

    // Drive one operation at the falling edge and move to just after the next rising edge.
    task automatic step(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic bi);
        @(negedge clk);
        sel = s; a = x; b = y; cin = ci; bin = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // Asserted from time zero.
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected 00000", {cout, out2, out1});
        end
        // Clock edges while held in reset must not load anything.
        step(4'd15, 8'hA5, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if ({cout, out2, out1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected 00000", {cout, out2, out1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_release: got %h expected 00000", {cout, out2, out1});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== {1'b0, 8'h5A, 8'hA5}) begin
            n_err++;
            $display("FAIL reset_first_edge: got %h expected %h", {cout, out2, out1},
                     {1'b0, 8'h5A, 8'hA5});
        end
        // Mid-cycle asynchronous reset with nonzero outputs.
        step(4'd7, 8'h00, 8'h0F, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected 00000", {cout, out2, out1});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_async_hold: got %h expected 00000", {cout, out2, out1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cout, out2, out1} !== {1'b0, 8'hF0, 8'hFF}) begin
            n_err++;
            $display("FAIL reset_async_resume: got %h expected %h", {cout, out2, out1},
                     {1'b0, 8'hF0, 8'hFF});
        end
    endtask

    task automatic test_add_sub;
        vec_t v[$];
        v.push_back('{4'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1});
        v.push_back('{4'd0, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 8'h00, 1'b0});
        v.push_back('{4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1});
        v.push_back('{4'd1, 8'h50, 8'h20, 1'b0, 1'b1, 8'h2F, 8'h00, 1'b0});
        v.push_back('{4'd1, 8'h20, 8'h20, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1});
        v.push_back('{4'd2, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1});
        v.push_back('{4'd3, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1});
        foreach (v[i]) begin
            step(v[i].sel, v[i].a, v[i].b, v[i].cin, v[i].bin);
            n_cmp++;
            if ({cout, out2, out1} !== {v[i].ec, v[i].e2, v[i].e1}) begin
                n_err++;
                $display("FAIL add_sub[%0d]: got %h expected %h", i, {cout, out2, out1},
                         {v[i].ec, v[i].e2, v[i].e1});
            end
        end
    endtask

    task automatic test_shift_rotate;
        vec_t v[$];
        v.push_back('{4'd8,  8'h81, 8'h00, 1'b1, 1'b1, 8'h02, 8'h00, 1'b1});
        v.push_back('{4'd9,  8'h81, 8'h00, 1'b1, 1'b1, 8'h40, 8'h00, 1'b1});
        v.push_back('{4'd10, 8'h81, 8'h00, 1'b0, 1'b0, 8'h03, 8'h00, 1'b1});
        v.push_back('{4'd11, 8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 8'h00, 1'b1});
        v.push_back('{4'd10, 8'h40, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0});
        foreach (v[i]) begin
            step(v[i].sel, v[i].a, v[i].b, v[i].cin, v[i].bin);
            n_cmp++;
            if ({cout, out2, out1} !== {v[i].ec, v[i].e2, v[i].e1}) begin
                n_err++;
                $display("FAIL shift_rotate[%0d]: got %h expected %h", i, {cout, out2, out1},
                         {v[i].ec, v[i].e2, v[i].e1});
            end
        end
    endtask

    task automatic test_cmp_mul;
        vec_t v[$];
        v.push_back('{4'd13, 8'h05, 8'h09, 1'b0, 1'b0, 8'h01, 8'hFC, 1'b1});
        v.push_back('{4'd14, 8'h05, 8'h09, 1'b0, 1'b0, 8'h09, 8'h05, 1'b1});
        v.push_back('{4'd13, 8'h33, 8'h33, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0});
        v.push_back('{4'd14, 8'h77, 8'h77, 1'b0, 1'b0, 8'h77, 8'h77, 1'b0});
`ifdef ALU8_MUL_EN
        v.push_back('{4'd12, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1});
        v.push_back('{4'd12, 8'h0F, 8'h0F, 1'b0, 1'b0, 8'hE1, 8'h00, 1'b0});
`else
        v.push_back('{4'd12, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
        v.push_back('{4'd12, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0});
`endif
        foreach (v[i]) begin
            step(v[i].sel, v[i].a, v[i].b, v[i].cin, v[i].bin);
            n_cmp++;
            if ({cout, out2, out1} !== {v[i].ec, v[i].e2, v[i].e1}) begin
                n_err++;
                $display("FAIL cmp_mul[%0d]: got %h expected %h", i, {cout, out2, out1},
                         {v[i].ec, v[i].e2, v[i].e1});
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  s;
        logic [7:0]  x, y;
        logic        ci, bi;
        logic [16:0] exp_v;
        for (int n = 0; n < 400; n++) begin
            s  = 4'($urandom_range(15));
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            bi = 1'($urandom);
            exp_v = model(int'(s), int'(x), int'(y), int'(ci), int'(bi));
            step(s, x, y, ci, bi);
            n_cmp++;
            if ({cout, out2, out1} !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d] sel=%0d a=%h b=%h cin=%b bin=%b: got %h expected %h",
                         n, s, x, y, ci, bi, {cout, out2, out1}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  x, y;
        logic        ci, bi;
        logic [16:0] exp_v;
        // Walk every opcode on consecutive cycles; each edge must show the
        // result of the inputs presented in the immediately preceding cycle.
        for (int n = 0; n < 64; n++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            bi = 1'($urandom);
            exp_v = model(n % 16, int'(x), int'(y), int'(ci), int'(bi));
            step(4'(n % 16), x, y, ci, bi);
            n_cmp++;
            if ({cout, out2, out1} !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back[%0d] sel=%0d: got %h expected %h",
                         n, n % 16, {cout, out2, out1}, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; bin = 1'b0; sel = 4'd0;
        test_reset();
        test_add_sub();
        test_shift_rotate();
        test_cmp_mul();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu8_unit
